unified_mem_arbiter: RTL and testbench

- Shares one single-ported unified memory between the core's instruction-fetch port and its data load/store port.
- Each requester holds a request until it receives a one-cycle ready pulse, so the core stalls while waiting.
- Arbitrates simultaneous requests, sequences one fixed-latency memory access at a time, and returns read data to the winner.
- Sits between the processor top level and the external memory model.

---
 rtl/unified_mem_arbiter.sv | 177 +++++++++++++++++
 tb/tb_unified_mem_arbiter.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/unified_mem_arbiter.sv
// unified_mem_arbiter: shares one fixed-latency single-ported memory between fetch and data ports.
// Optional build macro ARB_ROUND_ROBIN_EN: alternate the winner on simultaneous requests
// instead of always favouring the data port.
module unified_mem_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ready,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ready,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_err,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);
    localparam int CW = $clog2(MEM_LAT + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              is_data_q, is_data_d;
    logic              is_store_q, is_store_d;
    logic              mem_en_q, mem_en_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              if_ready_q, if_ready_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic              d_ready_q, d_ready_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
    logic              d_err_q, d_err_d;
    logic              busy_q, busy_d;
    logic              grant_data;

`ifdef ARB_ROUND_ROBIN_EN
    // rr_q = 1 means data was granted last, so fetch wins the next tie
    logic rr_q, rr_d;
    assign grant_data = d_req & (~if_req | ~rr_q);

    // last-grant pointer moves on every grant, misaligned ones included
    always_comb begin
        rr_d = (state_q == IDLE && (if_req || d_req)) ? grant_data : rr_q;
    end

    // last-grant pointer register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) rr_q <= 1'b0;
        else       rr_q <= rr_d;
    end
`else
    assign grant_data = d_req;
`endif

    // next-state and registered-output computation; outputs are set one cycle ahead
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        is_data_d   = is_data_q;
        is_store_d  = is_store_q;
        mem_en_d    = 1'b0;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_ready_d  = 1'b0;
        if_rdata_d  = if_rdata_q;
        d_ready_d   = 1'b0;
        d_rdata_d   = d_rdata_q;
        d_err_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (grant_data) begin
                    if (d_addr[1:0] != 2'b00) begin
                        state_d   = RESP;
                        d_ready_d = 1'b1;
                        d_err_d   = 1'b1;
                        d_rdata_d = '0;
                    end else begin
                        state_d     = ISSUE;
                        mem_en_d    = 1'b1;
                        mem_we_d    = d_we;
                        mem_addr_d  = d_addr;
                        mem_wdata_d = d_wdata;
                        is_data_d   = 1'b1;
                        is_store_d  = d_we;
                    end
                end else if (if_req) begin
                    state_d    = ISSUE;
                    mem_en_d   = 1'b1;
                    mem_we_d   = 1'b0;
                    mem_addr_d = if_addr;
                    is_data_d  = 1'b0;
                    is_store_d = 1'b0;
                end
            end
            ISSUE: begin
                state_d = WAIT;
                cnt_d   = CW'(MEM_LAT);
            end
            WAIT: begin
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = RESP;
                    if (is_data_q) begin
                        d_ready_d = 1'b1;
                        d_rdata_d = is_store_q ? '0 : mem_rdata;
                    end else begin
                        if_ready_d = 1'b1;
                        if_rdata_d = mem_rdata;
                    end
                end
            end
            RESP: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    // state and output registers; reset abandons any access in flight
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            is_data_q   <= 1'b0;
            is_store_q  <= 1'b0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_ready_q  <= 1'b0;
            if_rdata_q  <= '0;
            d_ready_q   <= 1'b0;
            d_rdata_q   <= '0;
            d_err_q     <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            is_data_q   <= is_data_d;
            is_store_q  <= is_store_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_ready_q  <= if_ready_d;
            if_rdata_q  <= if_rdata_d;
            d_ready_q   <= d_ready_d;
            d_rdata_q   <= d_rdata_d;
            d_err_q     <= d_err_d;
            busy_q      <= busy_d;
        end
    end

    assign if_ready  = if_ready_q;
    assign if_rdata  = if_rdata_q;
    assign d_ready   = d_ready_q;
    assign d_rdata   = d_rdata_q;
    assign d_err     = d_err_q;
    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign busy      = busy_q;
endmodule

// File: tb/tb_unified_mem_arbiter.sv
// tb_unified_mem_arbiter: scoreboard bench for the unified memory arbiter.
module tb_unified_mem_arbiter;
    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int LAT = 2;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          if_req = 1'b0;
    logic [AW-1:0] if_addr = '0;
    logic          if_ready;
    logic [DW-1:0] if_rdata;
    logic          d_req = 1'b0;
    logic          d_we = 1'b0;
    logic [AW-1:0] d_addr = '0;
    logic [DW-1:0] d_wdata = '0;
    logic          d_ready;
    logic [DW-1:0] d_rdata;
    logic          d_err;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;
    logic          busy;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    typedef struct {
        int          kind;
        int          at;
        logic [31:0] a;
        logic [31:0] d;
        logic        we;
        logic        err;
    } ev_t;
    ev_t q[$];

    logic [31:0] mem [0:1023];
    logic [31:0] rd_pipe [LAT];

    unified_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ready(d_ready), .d_rdata(d_rdata), .d_err(d_err),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // memory model: read data appears LAT cycles after the mem_en cycle
    always @(posedge clk) begin
        if (mem_en && mem_we) mem[mem_addr[11:2]] <= mem_wdata;
        rd_pipe[0] <= (mem_en && !mem_we) ? mem[mem_addr[11:2]] : 32'h0;
        for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign mem_rdata = rd_pipe[LAT-1];

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic void exp_mem(int at, logic [31:0] a, logic we, logic [31:0] d);
        ev_t e;
        e.kind = 0; e.at = at; e.a = a; e.we = we; e.d = d; e.err = 1'b0;
        q.push_back(e);
    endfunction

    function automatic void exp_rdy(int kind, int at, logic [31:0] d, logic err);
        ev_t e;
        e.kind = kind; e.at = at; e.a = '0; e.we = 1'b0; e.d = d; e.err = err;
        q.push_back(e);
    endfunction

    function automatic void pop_cmp(int kind, logic [31:0] a, logic [31:0] d, logic we, logic err);
        ev_t e;
        if (q.size() == 0) begin
            chk("unexpected_event_kind", 64'(kind), 64'd99);
            return;
        end
        e = q.pop_front();
        chk("event_kind", 64'(kind), 64'(e.kind));
        chk("event_cycle", 64'(cyc), 64'(e.at));
        if (kind == 0) begin
            chk("mem_addr", a, e.a);
            chk("mem_we", we, e.we);
            if (e.we) chk("mem_wdata", d, e.d);
        end else begin
            chk(kind == 1 ? "if_rdata" : "d_rdata", d, e.d);
            if (kind == 2) chk("d_err", err, e.err);
        end
    endfunction

    // monitor: every memory strobe and ready pulse is matched against the queue
    always @(negedge clk) begin
        if (if_ready && d_ready) chk("both_ready", 64'd1, 64'd0);
        if (mem_en) pop_cmp(0, mem_addr, mem_wdata, mem_we, 1'b0);
        if (if_ready) pop_cmp(1, '0, if_rdata, 1'b0, 1'b0);
        if (d_ready) pop_cmp(2, '0, d_rdata, 1'b0, d_err);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // wait for the wanted ready pulses, dropping each request as its ready is seen
    task automatic wait_ready(input bit want_if, input bit want_d);
        bit gi = !want_if;
        bit gd = !want_d;
        for (int n = 0; n < 40 && !(gi && gd); n++) begin
            @(negedge clk);
            if (if_ready && !gi) begin gi = 1'b1; if_req = 1'b0; end
            if (d_ready && !gd) begin gd = 1'b1; d_req = 1'b0; end
        end
        if (!(gi && gd)) begin
            chk("ready_timeout", {gi, gd}, 2'b11);
            if_req = 1'b0;
            d_req = 1'b0;
        end
    endtask

    task automatic fetch(input logic [31:0] a, input logic [31:0] exp);
        int t = cyc;
        if_req = 1'b1; if_addr = a;
        exp_mem(t + 1, a, 1'b0, '0);
        exp_rdy(1, t + LAT + 2, exp, 1'b0);
        wait_ready(1'b1, 1'b0);
        tick();
        chk("busy_after_fetch", busy, 1'b0);
    endtask

    task automatic dacc(input logic we, input logic [31:0] a, input logic [31:0] wd, input logic [31:0] exp);
        int t = cyc;
        d_req = 1'b1; d_we = we; d_addr = a; d_wdata = wd;
        if (a[1:0] != 2'b00) exp_rdy(2, t + 1, '0, 1'b1);
        else begin
            exp_mem(t + 1, a, we, wd);
            exp_rdy(2, t + LAT + 2, we ? 32'h0 : exp, 1'b0);
        end
        wait_ready(1'b0, 1'b1);
        tick();
        chk("busy_after_data", busy, 1'b0);
    endtask

    task automatic dual(input logic [31:0] ia, input logic [31:0] da, input logic [31:0] iexp,
                        input logic [31:0] dexp, input bit data_first);
        int t = cyc;
        if_req = 1'b1; if_addr = ia;
        d_req = 1'b1; d_we = 1'b0; d_addr = da;
        if (data_first) begin
            exp_mem(t + 1, da, 1'b0, '0);
            exp_rdy(2, t + LAT + 2, dexp, 1'b0);
            exp_mem(t + LAT + 4, ia, 1'b0, '0);
            exp_rdy(1, t + 2*LAT + 5, iexp, 1'b0);
        end else begin
            exp_mem(t + 1, ia, 1'b0, '0);
            exp_rdy(1, t + LAT + 2, iexp, 1'b0);
            exp_mem(t + LAT + 4, da, 1'b0, '0);
            exp_rdy(2, t + 2*LAT + 5, dexp, 1'b0);
        end
        wait_ready(1'b1, 1'b1);
        tick();
    endtask

    initial begin
        int t;
        for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
        mem[32'h40 >> 2]  = 32'h00500093;
        mem[32'h44 >> 2]  = 32'h11223344;
        mem[32'h48 >> 2]  = 32'h55667788;
        mem[32'h200 >> 2] = 32'hCAFEF00D;
        mem[32'h204 >> 2] = 32'h0BADC0DE;
        #1 reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_outputs", |{mem_en, mem_we, mem_addr, mem_wdata, if_ready, if_rdata,
                               d_ready, d_rdata, d_err, busy}, 1'b0);
        reset = 1'b0;
        tick();
        // first conflict after reset: data wins in both builds
        dual(32'h44, 32'h200, 32'h11223344, 32'hCAFEF00D, 1'b1);
        fetch(32'h40, 32'h00500093);
        dacc(1'b1, 32'h100, 32'hDEADBEEF, 32'h0);
        dacc(1'b0, 32'h100, 32'h0, 32'hDEADBEEF);
        // data was granted last: round robin hands the tie to fetch
`ifdef ARB_ROUND_ROBIN_EN
        dual(32'h48, 32'h204, 32'h55667788, 32'h0BADC0DE, 1'b0);
`else
        dual(32'h48, 32'h204, 32'h55667788, 32'h0BADC0DE, 1'b1);
`endif
        dacc(1'b0, 32'h102, 32'h0, 32'h0);
        dacc(1'b1, 32'h203, 32'h12345678, 32'h0);
        dacc(1'b0, 32'h200, 32'h0, 32'hCAFEF00D);
        // fetch request held through its ready: second access strobes two cycles later
        t = cyc;
        if_req = 1'b1; if_addr = 32'h40;
        exp_mem(t + 1, 32'h40, 1'b0, '0);
        exp_rdy(1, t + LAT + 2, 32'h00500093, 1'b0);
        exp_mem(t + LAT + 4, 32'h40, 1'b0, '0);
        exp_rdy(1, t + 2*LAT + 5, 32'h00500093, 1'b0);
        @(negedge clk);
        for (int n = 0; n < 20 && !if_ready; n++) @(negedge clk);
        if (!if_ready) chk("held_first_ready", if_ready, 1'b1);
        wait_ready(1'b1, 1'b0);
        tick();
        // reset during WAIT abandons the fetch; the held request is regranted afterwards
        t = cyc;
        if_req = 1'b1; if_addr = 32'h44;
        exp_mem(t + 1, 32'h44, 1'b0, '0);
        tick();
        tick();
        chk("busy_in_wait", busy, 1'b1);
        reset = 1'b1;
        #1;
        chk("reset_async_outputs", |{mem_en, mem_we, mem_addr, mem_wdata, if_ready, if_rdata,
                                     d_ready, d_rdata, d_err, busy}, 1'b0);
        tick();
        tick();
        reset = 1'b0;
        t = cyc;
        exp_mem(t + 1, 32'h44, 1'b0, '0);
        exp_rdy(1, t + LAT + 2, 32'h11223344, 1'b0);
        wait_ready(1'b1, 1'b0);
        tick();
        chk("busy_after_regrant", busy, 1'b0);
        repeat (5) tick();
        chk("leftover_events", 64'(q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
